radix4_div_responder: RTL and testbench
=======================================

Name: radix4_div_responder

Overview:
- Multi-cycle unsigned integer divider on the responder side of the muldiv unit's divide handshake.
- The muldiv unit pulses a request carrying pre-made magnitudes, then waits; this block iterates two quotient bits per cycle and returns quotient and remainder with a one-cycle valid pulse.
- Sign fix-up belongs to the initiator, not to this block.
- The divide-by-zero result follows the RISC-V M convention, so the initiator may pass it straight through.

Parameters:
- WIDTH, 32, operand/result width; must be even and ≥ 4.

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- input_valid_i  input  1  request strobe; operands are sampled in the cycle it is accepted.
- dividend_i  input  WIDTH  unsigned dividend.
- divisor_i  input  WIDTH  unsigned divisor.
- busy_o  output  1  high while a request is in flight (CALC, or ZERO/EARLY path before DONE).
- quotient_o  output  WIDTH  quotient; valid only while output_valid_o is high.
- remainder_o  output  WIDTH  remainder; valid only while output_valid_o is high.
- output_valid_o  output  1  single-cycle completion pulse.

Behaviour:
- Reset (rst_ni low, asynchronous): state is IDLE; busy_o, output_valid_o, quotient_o, remainder_o, the iteration counter and all working registers are 0.
- Reset mid-operation aborts the division; no output_valid_o pulse is ever produced for that request.
- States are IDLE, CALC and DONE.
- IDLE:
  - input_valid_i high → latch the dividend into the working quotient/shift register.
  - Latch divisor, 2×divisor and 3×divisor, each WIDTH+2 bits wide.
  - Clear the partial remainder (WIDTH+2 bits) and set the counter to WIDTH/2.
  - Go to CALC.
  - Exception: divisor_i == 0 → go directly to DONE with quotient = all-ones and remainder = dividend_i.
- CALC, once per cycle:
  - Shift the top 2 bits of the dividend register into the partial remainder: r' = 4r + bits.
  - Compare r' against 3d, 2d and d, in that priority, to pick the digit q ∈ {3, 2, 1, 0}.
  - Subtract q·d from r' and shift q into the low end of the quotient register.
  - Decrement the counter; counter reaching 1 on this cycle → go to DONE.
- DONE:
  - output_valid_o = 1 for exactly this one cycle.
  - quotient_o and remainder_o are registered and shown this cycle.
  - Next state is IDLE, or CALC if input_valid_i is high in this cycle (back-to-back acceptance).
- Latency, measured from the acceptance edge to the output_valid_o cycle:
  - Normal path: WIDTH/2 + 1 cycles (17 for WIDTH=32).
  - Divide-by-zero path: 1 cycle.
- busy_o = (state != IDLE) && !(state == DONE).
  - busy_o is low in the DONE cycle so the initiator can issue its next request.
- input_valid_i while in CALC is ignored; operands are not re-sampled.
- quotient_o/remainder_o hold their last values after DONE; they need not be zeroed.
- Invariant at completion: dividend = quotient·divisor + remainder, with remainder < divisor (divisor ≠ 0).
- Widths:
  - Partial remainder and the multiples of d are WIDTH+2 bits, so 3d never overflows.
  - Comparisons are unsigned.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - In IDLE, an accepted request with divisor_i ≠ 0 and dividend_i < divisor_i goes directly to DONE with quotient = 0 and remainder = dividend_i.
  - Latency on that path is 1 cycle.
  - Divide-by-zero keeps priority over this check.
- Undefined: the comparator is absent and such requests take the full WIDTH/2 + 1 cycles, producing the same results.

Test Plan:
- Reset, then 100/7 accepted at cycle 0 → busy_o high cycles 1–16, output_valid_o only at cycle 17; quotient 14, remainder 2.
- 0xFFFFFFFF/1 → quotient 0xFFFFFFFF, remainder 0. Then 0xFFFFFFFF/0xFFFFFFFF → quotient 1, remainder 0. Both complete at latency 17.
- 0x1234/0 → output_valid_o at cycle 1; quotient 0xFFFFFFFF, remainder 0x00001234; busy_o never high.
- Request 100/7, then 9/3 presented in the DONE cycle → first result 14r2, second result 3r0 exactly 17 cycles later. A 50/5 pulse during CALC is ignored; no third output_valid_o pulse appears.
- rst_ni pulsed low at cycle 8 of 1000/3 → all outputs 0 immediately, no output_valid_o pulse; a new 1000/3 then returns 333r1 at latency 17.
- With DIV_EARLY_OUT_EN, 5/9 → quotient 0, remainder 5 at latency 1. Without the macro, the same result at latency 17.

Source files
------------

// File: rtl/radix4_div_responder_if.sv
// Divide handshake between the muldiv initiator and the radix-4 divider.
//   master : initiator side (drives request strobe and operand magnitudes)
//   slave  : divider side (returns busy, quotient, remainder, completion pulse)
// Signals:
//   input_valid_i  request strobe
//   dividend_i     unsigned dividend magnitude
//   divisor_i      unsigned divisor magnitude
//   busy_o         request in flight
//   quotient_o     quotient, valid with output_valid_o
//   remainder_o    remainder, valid with output_valid_o
//   output_valid_o single-cycle completion pulse
interface radix4_div_responder_if #(
   parameter int WIDTH = 32
);
   logic             input_valid_i;
   logic [WIDTH-1:0] dividend_i;
   logic [WIDTH-1:0] divisor_i;
   logic             busy_o;
   logic [WIDTH-1:0] quotient_o;
   logic [WIDTH-1:0] remainder_o;
   logic             output_valid_o;

   modport master (
      output input_valid_i, dividend_i, divisor_i,
      input  busy_o, quotient_o, remainder_o, output_valid_o
   );

   modport slave (
      input  input_valid_i, dividend_i, divisor_i,
      output busy_o, quotient_o, remainder_o, output_valid_o
   );
endinterface

// File: rtl/radix4_div_responder.sv
// Radix-4 multi-cycle unsigned divider, responder side of the muldiv divide
// handshake. Produces two quotient bits per cycle; WIDTH/2 + 1 cycles from
// acceptance to the output_valid_o pulse. Divide-by-zero returns all-ones
// quotient and remainder = dividend in one cycle (RISC-V M convention).
// Optional feature macro: DIV_EARLY_OUT_EN -- when defined, dividend < divisor
// completes in one cycle with quotient 0, remainder = dividend.
// Ports:
//   clk_i  clock (rising edge)
//   rst_ni asynchronous active-low reset
//   div    radix4_div_responder_if.slave (request in, result out)
module radix4_div_responder #(
   parameter int WIDTH = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   radix4_div_responder_if.slave  div
);
   localparam int CW = $clog2(WIDTH/2 + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] qr;          // dividend shifts out the top, quotient digits shift in the bottom
   logic [WIDTH+1:0] rem;
   logic [WIDTH+1:0] d1, d2, d3;
   logic [CW-1:0]    cnt;

   logic [WIDTH+1:0] r_sh, r_nx;
   logic [1:0]       digit;
   logic [WIDTH-1:0] qr_nx;
   logic             take;

   // DONE accepts a new request so the initiator can issue back-to-back.
   assign take = div.input_valid_i && (state == IDLE || state == DONE);

   always_comb begin
      r_sh  = (rem << 2) | {{WIDTH{1'b0}}, qr[WIDTH-1:WIDTH-2]};
      digit = 2'd0;
      r_nx  = r_sh;
      if (r_sh >= d3) begin
         digit = 2'd3;
         r_nx  = r_sh - d3;
      end else if (r_sh >= d2) begin
         digit = 2'd2;
         r_nx  = r_sh - d2;
      end else if (r_sh >= d1) begin
         digit = 2'd1;
         r_nx  = r_sh - d1;
      end
      qr_nx = {qr[WIDTH-3:0], digit};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state              <= IDLE;
         qr                 <= '0;
         rem                <= '0;
         d1                 <= '0;
         d2                 <= '0;
         d3                 <= '0;
         cnt                <= '0;
         div.busy_o         <= 1'b0;
         div.output_valid_o <= 1'b0;
         div.quotient_o     <= '0;
         div.remainder_o    <= '0;
      end else begin
         div.output_valid_o <= 1'b0;
         div.busy_o         <= 1'b0;
         if (take) begin
            if (div.divisor_i == '0) begin
               state              <= DONE;
               div.quotient_o     <= '1;
               div.remainder_o    <= div.dividend_i;
               div.output_valid_o <= 1'b1;
            end
`ifdef DIV_EARLY_OUT_EN
            else if (div.dividend_i < div.divisor_i) begin
               state              <= DONE;
               div.quotient_o     <= '0;
               div.remainder_o    <= div.dividend_i;
               div.output_valid_o <= 1'b1;
            end
`endif
            else begin
               state      <= CALC;
               qr         <= div.dividend_i;
               rem        <= '0;
               d1         <= {2'b00, div.divisor_i};
               d2         <= {1'b0, div.divisor_i, 1'b0};
               d3         <= {2'b00, div.divisor_i} + {1'b0, div.divisor_i, 1'b0};
               cnt        <= CW'(WIDTH/2);
               div.busy_o <= 1'b1;
            end
         end else begin
            case (state)
               CALC: begin
                  qr  <= qr_nx;
                  rem <= r_nx;
                  cnt <= cnt - 1'b1;
                  if (cnt == CW'(1)) begin
                     state              <= DONE;
                     div.quotient_o     <= qr_nx;
                     div.remainder_o    <= r_nx[WIDTH-1:0];
                     div.output_valid_o <= 1'b1;
                  end else begin
                     div.busy_o <= 1'b1;
                  end
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_radix4_div_responder.sv
module tb_radix4_div_responder;
   localparam int W = 32;
   localparam int LAT = W/2 + 1;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      int           cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   npulse = 0;
   int   nexp = 0;
   exp_t sb[$];

   radix4_div_responder_if #(.WIDTH(W)) dif ();

   radix4_div_responder #(.WIDTH(W)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .div    (dif.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: every completion pulse must match the oldest request.
   always @(negedge clk) begin
      if (rst_n && dif.output_valid_o) begin
         npulse++;
         if (sb.size() == 0) begin
            chk("unexpected_pulse", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient", 64'(dif.quotient_o), 64'(e.q));
            chk("remainder", 64'(dif.remainder_o), 64'(e.r));
            chk("latency", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   // Drive one request for a single cycle; the expected result is pushed first.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int   lat;
      lat = LAT;
      if (b == 0) begin
         e.q = '1;
         e.r = a;
         lat = 1;
      end else begin
         e.q = a / b;
         e.r = a % b;
`ifdef DIV_EARLY_OUT_EN
         if (a < b) lat = 1;
`endif
      end
      e.cyc = cyc + lat;
      sb.push_back(e);
      nexp++;
      dif.input_valid_i = 1'b1;
      dif.dividend_i    = a;
      dif.divisor_i     = b;
      @(posedge clk); #1;
      dif.input_valid_i = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() != 0) begin
         chk("timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      dif.input_valid_i = 1'b0;
      dif.dividend_i    = '0;
      dif.divisor_i     = '0;
      #2;
      chk("rst_busy", 64'(dif.busy_o), 64'd0);
      chk("rst_valid", 64'(dif.output_valid_o), 64'd0);
      chk("rst_quo", 64'(dif.quotient_o), 64'd0);
      chk("rst_rem", 64'(dif.remainder_o), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // 100/7: busy through cycles 1..16, pulse at 17.
      send(100, 7);
      for (int i = 1; i < LAT; i++) begin
         @(negedge clk);
         chk("busy_calc", 64'(dif.busy_o), 64'd1);
         chk("valid_calc", 64'(dif.output_valid_o), 64'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("busy_done", 64'(dif.busy_o), 64'd0);
      wait_idle();

      send(32'hFFFF_FFFF, 1);
      wait_idle();
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_idle();

      // Divide by zero: one-cycle path, busy never rises.
      send(32'h1234, 0);
      @(negedge clk);
      chk("busy_dbz", 64'(dif.busy_o), 64'd0);
      wait_idle();

      // Back-to-back in DONE, plus an ignored request during CALC.
      send(100, 7);
      repeat (4) @(posedge clk);
      #1;
      dif.input_valid_i = 1'b1;
      dif.dividend_i    = 50;
      dif.divisor_i     = 5;
      @(posedge clk); #1;
      dif.input_valid_i = 1'b0;
      repeat (LAT - 6) @(posedge clk);
      #1;
      send(9, 3);
      wait_idle();
      repeat (20) @(posedge clk);
      #1;

      // Reset mid-operation: request is not scoreboarded, it must never complete.
      dif.input_valid_i = 1'b1;
      dif.dividend_i    = 1000;
      dif.divisor_i     = 3;
      @(posedge clk); #1;
      dif.input_valid_i = 1'b0;
      repeat (7) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_busy", 64'(dif.busy_o), 64'd0);
      chk("abort_valid", 64'(dif.output_valid_o), 64'd0);
      chk("abort_quo", 64'(dif.quotient_o), 64'd0);
      chk("abort_rem", 64'(dif.remainder_o), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (LAT + 2) @(posedge clk);
      #1;
      send(1000, 3);
      wait_idle();

      // dividend < divisor: 1 cycle with the early-out macro, full latency otherwise.
      send(5, 9);
      wait_idle();

      for (int i = 0; i < 6; i++) begin
         logic [W-1:0] a, b;
         a = $urandom;
         b = (i % 2 == 0) ? W'($urandom_range(1, 255)) : W'($urandom);
         send(a, b);
         wait_idle();
      end

      chk("pulse_count", 64'(npulse), 64'(nexp));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
